// File: rtl/button_bank_debouncer.sv
// Multi-key push-button debouncer with a shared tick, long-press detection and a round-robin event queue.
// Optional auto-repeat events are built when BUTTON_BANK_AUTO_REPEAT_EN is defined.
module button_bank_debouncer #(
  parameter int unsigned NUM_KEYS       = 4,
  parameter int unsigned ACTIVE_LOW     = 1,
  parameter int unsigned TICK_DIV       = 50000,
  parameter int unsigned DEBOUNCE_TICKS = 10,
  parameter int unsigned LONG_TICKS     = 1000,
  parameter int unsigned REPEAT_TICKS   = 100,
  localparam int unsigned KW = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] key_in,
  output logic [NUM_KEYS-1:0] key_state,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic                evt_valid,
  input  logic                evt_ready,
  output logic [KW-1:0]       evt_key,
  output logic [1:0]          evt_type,
  output logic                evt_overflow,
  input  logic                clear_overflow
);

  localparam int unsigned PW   = $clog2(TICK_DIV);
  localparam int unsigned DW   = $clog2(DEBOUNCE_TICKS + 1);
  localparam int unsigned MAXC = (LONG_TICKS > REPEAT_TICKS) ? LONG_TICKS : REPEAT_TICKS;
  localparam int unsigned CW   = $clog2(MAXC + 1);
  localparam logic [NUM_KEYS-1:0] PIN_IDLE = (ACTIVE_LOW != 0) ? {NUM_KEYS{1'b1}} : '0;

  logic [NUM_KEYS-1:0]          sync1_q, sync1_d, sync2_q, sync2_d;
  logic [PW-1:0]                pre_q, pre_d;
  logic [NUM_KEYS-1:0][DW-1:0]  deb_q, deb_d;
  logic [NUM_KEYS-1:0]          stable_q, stable_d;
  logic [NUM_KEYS-1:0][CW-1:0]  hold_q, hold_d;
  logic [NUM_KEYS-1:0]          key_state_q, key_state_d;
  logic [NUM_KEYS-1:0]          key_press_q, key_press_d;
  logic [NUM_KEYS-1:0]          key_release_q, key_release_d;
  logic [NUM_KEYS-1:0][3:0]     pend_q, pend_d;
  logic                         evt_valid_q, evt_valid_d;
  logic [KW-1:0]                evt_key_q, evt_key_d;
  logic [1:0]                   evt_type_q, evt_type_d;
  logic [KW-1:0]                last_q, last_d;
  logic                         ovf_q, ovf_d;
`ifdef BUTTON_BANK_AUTO_REPEAT_EN
  logic [NUM_KEYS-1:0][CW-1:0]  rep_q, rep_d;
`endif

  logic [NUM_KEYS-1:0]          synced_c, long_c, rep_c;
  logic                         tick_c, xfer_c, arb_found_c;
  logic [NUM_KEYS-1:0][3:0]     set_c, clr_c, pend_avail_c;
  int unsigned                  arb_idx;

  always_comb begin
    sync1_d       = key_in;
    sync2_d       = sync1_q;
    synced_c      = (ACTIVE_LOW != 0) ? ~sync2_q : sync2_q;
    tick_c        = (pre_q == PW'(TICK_DIV - 1));
    pre_d         = tick_c ? '0 : pre_q + 1'b1;
    stable_d      = stable_q;
    deb_d         = deb_q;
    hold_d        = hold_q;
    long_c        = '0;
    rep_c         = '0;
`ifdef BUTTON_BANK_AUTO_REPEAT_EN
    rep_d         = rep_q;
`endif
    for (int k = 0; k < NUM_KEYS; k++) begin
      // Any agreement with the stable level restarts the debounce window.
      if (synced_c[k] == stable_q[k]) begin
        deb_d[k] = '0;
      end else if (tick_c) begin
        if (deb_q[k] == DW'(DEBOUNCE_TICKS - 1)) begin
          stable_d[k] = ~stable_q[k];
          deb_d[k]    = '0;
        end else begin
          deb_d[k] = deb_q[k] + 1'b1;
        end
      end
      if (!stable_q[k]) begin
        hold_d[k] = '0;
      end else if (tick_c && (hold_q[k] != CW'(LONG_TICKS))) begin
        hold_d[k] = hold_q[k] + 1'b1;
        long_c[k] = (hold_q[k] == CW'(LONG_TICKS - 1));
      end
`ifdef BUTTON_BANK_AUTO_REPEAT_EN
      if (!stable_q[k]) begin
        rep_d[k] = '0;
      end else if (tick_c && (hold_q[k] == CW'(LONG_TICKS))) begin
        if (rep_q[k] == CW'(REPEAT_TICKS - 1)) begin
          rep_d[k] = '0;
          rep_c[k] = 1'b1;
        end else begin
          rep_d[k] = rep_q[k] + 1'b1;
        end
      end
`endif
    end
    key_state_d   = stable_q;
    key_press_d   = stable_q & ~key_state_q;
    key_release_d = ~stable_q & key_state_q;
  end

  // Pending-event bookkeeping: a new strobe on an occupied slot is merged and flagged.
  always_comb begin
    xfer_c = evt_valid_q && evt_ready;
    for (int k = 0; k < NUM_KEYS; k++) begin
      set_c[k] = {key_release_q[k], rep_c[k], long_c[k], key_press_q[k]};
      for (int t = 0; t < 4; t++) begin
        clr_c[k][t] = xfer_c && (evt_key_q == KW'(k)) && (evt_type_q == 2'(t));
      end
    end
    pend_avail_c = pend_q & ~clr_c;
    pend_d       = pend_avail_c | set_c;
    ovf_d        = (|(pend_avail_c & set_c)) | (ovf_q & ~clear_overflow);
  end

  // Round-robin over keys after the last one served; lowest type wins within a key.
  always_comb begin
    evt_valid_d = evt_valid_q;
    evt_key_d   = evt_key_q;
    evt_type_d  = evt_type_q;
    last_d      = last_q;
    arb_found_c = 1'b0;
    arb_idx     = 0;
    if (!evt_valid_q || xfer_c) begin
      evt_valid_d = 1'b0;
      for (int unsigned i = 1; i <= NUM_KEYS; i++) begin
        arb_idx = (32'(last_q) + i) % NUM_KEYS;
        if (!arb_found_c && (|pend_avail_c[arb_idx])) begin
          arb_found_c = 1'b1;
          evt_valid_d = 1'b1;
          evt_key_d   = KW'(arb_idx);
          last_d      = KW'(arb_idx);
          for (int t = 3; t >= 0; t--) begin
            if (pend_avail_c[arb_idx][t]) evt_type_d = 2'(t);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q       <= PIN_IDLE;
      sync2_q       <= PIN_IDLE;
      pre_q         <= '0;
      deb_q         <= '0;
      stable_q      <= '0;
      hold_q        <= '0;
      key_state_q   <= '0;
      key_press_q   <= '0;
      key_release_q <= '0;
      pend_q        <= '0;
      evt_valid_q   <= 1'b0;
      evt_key_q     <= '0;
      evt_type_q    <= '0;
      last_q        <= KW'(NUM_KEYS - 1);
      ovf_q         <= 1'b0;
`ifdef BUTTON_BANK_AUTO_REPEAT_EN
      rep_q         <= '0;
`endif
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      pre_q         <= pre_d;
      deb_q         <= deb_d;
      stable_q      <= stable_d;
      hold_q        <= hold_d;
      key_state_q   <= key_state_d;
      key_press_q   <= key_press_d;
      key_release_q <= key_release_d;
      pend_q        <= pend_d;
      evt_valid_q   <= evt_valid_d;
      evt_key_q     <= evt_key_d;
      evt_type_q    <= evt_type_d;
      last_q        <= last_d;
      ovf_q         <= ovf_d;
`ifdef BUTTON_BANK_AUTO_REPEAT_EN
      rep_q         <= rep_d;
`endif
    end
  end

  assign key_state    = key_state_q;
  assign key_press    = key_press_q;
  assign key_release  = key_release_q;
  assign evt_valid    = evt_valid_q;
  assign evt_key      = evt_key_q;
  assign evt_type     = evt_type_q;
  assign evt_overflow = ovf_q;

endmodule

// File: tb/tb_button_bank_debouncer.sv
// Directed bench for button_bank_debouncer: clean press, bounce, long press, backpressure, fairness, reset.
module tb_button_bank_debouncer;

  localparam int unsigned NK = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [NK-1:0] key_in;
  logic [NK-1:0] key_state, key_press, key_release;
  logic          evt_valid, evt_ready, evt_overflow, clear_overflow;
  logic [1:0]    evt_key;
  logic [1:0]    evt_type;

  int total = 0;
  int bad   = 0;

  logic [3:0] log_q[$];
  int         press_cnt[NK];
  logic       any_valid;

  button_bank_debouncer #(
    .NUM_KEYS(NK), .ACTIVE_LOW(1), .TICK_DIV(4), .DEBOUNCE_TICKS(3),
    .LONG_TICKS(10), .REPEAT_TICKS(100)
  ) dut (
    .clk(clk), .reset(reset), .key_in(key_in),
    .key_state(key_state), .key_press(key_press), .key_release(key_release),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_key(evt_key),
    .evt_type(evt_type), .evt_overflow(evt_overflow), .clear_overflow(clear_overflow)
  );

  always #5 clk = ~clk;

  // Record accepted events and press strobes.
  always @(posedge clk) begin
    if (!reset) begin
      if (evt_valid && evt_ready) log_q.push_back({evt_key, evt_type});
      if (evt_valid) any_valid <= 1'b1;
      for (int k = 0; k < NK; k++) if (key_press[k]) press_cnt[k] <= press_cnt[k] + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_press(input int k, input int budget, output int n);
    n = 0;
    while (!key_press[k] && n < budget) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    int n;
    for (int k = 0; k < NK; k++) press_cnt[k] = 0;
    any_valid      = 1'b0;
    reset          = 1'b1;
    key_in         = '1;
    evt_ready      = 1'b1;
    clear_overflow = 1'b0;
    cycles(2);
    check("rst_state", 32'(key_state), 0);
    check("rst_press", 32'(key_press), 0);
    check("rst_valid", 32'(evt_valid), 0);
    check("rst_ovf", 32'(evt_overflow), 0);
    check("rst_payload", 32'({evt_key, evt_type}), 0);
    reset = 1'b0;
    cycles(5);
    check("idle_valid", 32'(evt_valid), 0);

    // Clean press on key 1
    key_in[1] = 1'b0;
    wait_press(1, 20, n);
    check("k1_press_strobe", 32'(key_press[1]), 1);
    check("k1_latency_ok", 32'(n <= 15), 1);
    check("k1_state", 32'(key_state[1]), 1);
    cycles(4);
    check("k1_press_cnt", 32'(press_cnt[1]), 1);
    check("k1_evt_count", 32'(log_q.size()), 1);
    check("k1_evt", 32'(log_q[0]), 32'h4);
    log_q.delete();
    key_in[1] = 1'b1;
    cycles(25);
    check("k1_rel_state", 32'(key_state[1]), 0);
    check("k1_rel_count", 32'(log_q.size()), 1);
    check("k1_rel_evt", 32'(log_q[0]), 32'h7);
    log_q.delete();

    // Bounce on key 0
    any_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      key_in[0] = ~key_in[0];
      cycles(5);
    end
    key_in[0] = 1'b1;
    cycles(5);
    check("bounce_state", 32'(key_state[0]), 0);
    check("bounce_strobes", 32'(press_cnt[0]), 0);
    check("bounce_valid", 32'(any_valid), 0);
    check("bounce_evts", 32'(log_q.size()), 0);

    // Long press on key 2
    key_in[2] = 1'b0;
    cycles(70);
    check("long_count", 32'(log_q.size()), 2);
    check("long_evt0", 32'(log_q[0]), 32'h8);
    check("long_evt1", 32'(log_q[1]), 32'h9);
    key_in[2] = 1'b1;
    cycles(25);
    check("long_rel_count", 32'(log_q.size()), 3);
    check("long_rel_evt", 32'(log_q[2]), 32'hB);
    log_q.delete();

    // Backpressure and overflow on key 3
    evt_ready = 1'b0;
    key_in[3] = 1'b0; cycles(20);
    key_in[3] = 1'b1; cycles(20);
    check("bp_hold_type", 32'({evt_valid, evt_key, evt_type}), 32'h1C);
    key_in[3] = 1'b0; cycles(20);
    key_in[3] = 1'b1; cycles(20);
    check("bp_valid", 32'(evt_valid), 1);
    check("bp_payload", 32'({evt_key, evt_type}), 32'hC);
    check("bp_ovf", 32'(evt_overflow), 1);
    check("bp_none_taken", 32'(log_q.size()), 0);
    evt_ready = 1'b1;
    cycles(1);
    check("bp_second", 32'({evt_valid, evt_key, evt_type}), 32'h1F);
    cycles(1);
    check("bp_drained", 32'(evt_valid), 0);
    check("bp_log_count", 32'(log_q.size()), 2);
    check("bp_log0", 32'(log_q[0]), 32'hC);
    check("bp_log1", 32'(log_q[1]), 32'hF);
    check("bp_ovf_sticky", 32'(evt_overflow), 1);
    clear_overflow = 1'b1;
    cycles(1);
    clear_overflow = 1'b0;
    check("ovf_cleared", 32'(evt_overflow), 0);
    log_q.delete();

    // Fairness: keys 0 and 3 together
    key_in[0] = 1'b0;
    key_in[3] = 1'b0;
    cycles(70);
    check("fair_count", 32'(log_q.size()), 4);
    check("fair_evt0", 32'(log_q[0]), 32'h0);
    check("fair_evt1", 32'(log_q[1]), 32'hC);
    check("fair_evt2", 32'(log_q[2]), 32'h1);
    check("fair_evt3", 32'(log_q[3]), 32'hD);
    key_in[0] = 1'b1;
    key_in[3] = 1'b1;
    cycles(25);
    check("fair_rel_count", 32'(log_q.size()), 6);
    check("fair_evt4", 32'(log_q[4]), 32'h3);
    check("fair_evt5", 32'(log_q[5]), 32'hF);
    log_q.delete();

    // Reset while key 1 held with an event pending
    evt_ready = 1'b0;
    key_in[1] = 1'b0;
    cycles(20);
    check("mid_pending", 32'({evt_valid, evt_key, evt_type}), 32'h14);
    reset = 1'b1;
    #1;
    check("mid_rst_state", 32'(key_state), 0);
    check("mid_rst_valid", 32'(evt_valid), 0);
    check("mid_rst_payload", 32'({evt_key, evt_type, evt_overflow}), 0);
    cycles(3);
    reset = 1'b0;
    evt_ready = 1'b1;
    wait_press(1, 25, n);
    check("mid_repress", 32'(key_press[1]), 1);
    cycles(4);
    check("mid_evt_count", 32'(log_q.size()), 1);
    check("mid_evt", 32'(log_q[0]), 32'h4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/button_bank_debouncer.md
Name: button_bank_debouncer

Overview:
- Parametrised successor to the single-key push-button debouncer; serves the whole bank of board and hat buttons from one block.
- Synchronises and debounces NUM_KEYS raw inputs with programmable polarity and one shared timebase.
- Per key: stable level, press/release strobes, long-press detection.
- Queues all key events behind a valid/ready port for downstream consumers (scroll display controller, soft CPU).

Parameters:
- NUM_KEYS, 4, number of key channels (1..16)
- ACTIVE_LOW, 1, 1 = raw pin low means pressed (hat keys with weak pull-up)
- TICK_DIV, 50000, clk cycles per debounce tick (1 ms at 50 MHz); must be >= 2
- DEBOUNCE_TICKS, 10, consecutive disagreeing ticks needed to flip the stable state; must be >= 1
- LONG_TICKS, 1000, ticks held before a long-press event
- REPEAT_TICKS, 100, ticks between auto-repeat events (optional feature only)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- key_in  in  NUM_KEYS  raw asynchronous pins
- key_state  out  NUM_KEYS  debounced level, 1 = pressed
- key_press  out  NUM_KEYS  one-cycle strobe on stable released->pressed
- key_release  out  NUM_KEYS  one-cycle strobe on stable pressed->released
- evt_valid  out  1  event available
- evt_ready  in  1  consumer accepts the event
- evt_key  out  KW  key index; KW = max(1, clog2(NUM_KEYS))
- evt_type  out  2  0 press, 1 long, 2 repeat, 3 release
- evt_overflow  out  1  sticky flag: an event was merged/lost
- clear_overflow  in  1  clears evt_overflow

Behaviour:
- Reset: clk and reset are decided as above; reset is asynchronous active-high. While reset is high, every output is 0, all counters are 0, all stable states are "released" and no events are pending.
- Input path: 2-FF synchroniser per key, then inversion if ACTIVE_LOW.
- Tick: prescaler counts 0..TICK_DIV-1; tick is high for one clk when the count wraps.
- Debounce, per key:
  - If the synced value equals stable, the counter clears immediately (glitch rejection).
  - Otherwise the counter increments on each tick.
  - When the counter reaches DEBOUNCE_TICKS, stable flips and the counter clears.
- Latency: the key_press/key_release strobe asserts 1 clk after the flip. Worst case from a pin change is 2 + DEBOUNCE_TICKS*TICK_DIV + 1 clks.
- Hold counter, per key:
  - Counts ticks while stable is pressed; saturates at LONG_TICKS.
  - Emits the long event exactly once per press, on the tick where it reaches LONG_TICKS.
  - Clears on release.
- Event pending: one pending bit per (key, type); each set on its source strobe.
  - If a source strobe arrives while that bit is already set, the bit stays set and evt_overflow sets.
- Arbiter:
  - When evt_valid=0 or a transfer occurs, the next event is chosen by round-robin over keys, starting after the last-served key.
  - Within a key, the lowest type index is served first, so a press always precedes its release.
  - The selection is registered, so evt_valid appears 1 clk after the pending bit.
- Handshake:
  - A transfer occurs when evt_valid && evt_ready; it clears that pending bit.
  - evt_key and evt_type stay stable while evt_valid && !evt_ready.
  - Back-to-back transfers sustain 1 event/clk.
  - Once evt_valid asserts, it never drops without a transfer.
- Overflow: evt_overflow stays set until clear_overflow. If set and clear happen in the same cycle, set wins.
- Reset mid-press: after reset deasserts with a key held, stable starts "released", so a fresh press is detected after debounce.

Optional Feature:
- Macro: BUTTON_BANK_AUTO_REPEAT_EN.
- Defined: after the long event, while the key is still held, a repeat event (type 2) is emitted every REPEAT_TICKS ticks. The repeat counter clears on release.
- Undefined: no repeat logic is built; type 2 is never produced and REPEAT_TICKS is ignored.

Test Plan:
Bench parameters: TICK_DIV=4, DEBOUNCE_TICKS=3, LONG_TICKS=10, ACTIVE_LOW=1.
- Clean press: drive key_in[1] low and hold -> key_state[1]=1 and one key_press[1] strobe within 2+12+1 clks; event {key=1, type=0} appears with evt_ready=1.
- Bounce rejection: toggle key_in[0] low/high every 5 clks for 60 clks -> key_state stays 0, no strobes, evt_valid stays 0.
- Long press: hold key 2 for 12 ticks -> events press then long (type 1) exactly once; on release a release event (type 3) follows.
- Backpressure and overflow: evt_ready=0; press/release key 3 twice -> one press and one release pending, evt_overflow=1, payload stable. Then evt_ready=1 -> type 0 then type 3 on consecutive clks. Then clear_overflow -> flag 0.
- Fairness: keys 0 and 3 pressed in the same cycle with evt_ready=1 -> keys served alternately per round-robin; none starved.
- Reset mid-operation: assert reset while key 1 is held and an event is pending -> all outputs 0 immediately. Release reset -> a press event is produced again after debounce.
